ysyx_23060201_ifu_hs: RTL and testbench

Handshaked, multi-cycle instruction fetch unit for the NPC core. Issues single-beat reads on an AXI-lite-style read channel (AR/R) and holds returned instructions in a small FIFO. Delivers {pc, inst} to the IDU over a valid/ready handshake. Successor to the combinational DPI fetch path: supports arbitrary memory latency, back-pressure and mid-flight redirects.

---
 rtl/ysyx_23060201_pkg.sv | 14 +
 rtl/ysyx_23060201_ifu_fifo.sv | 47 ++++
 rtl/ysyx_23060201_ifu_hs.sv | 119 +++++++++++
 tb/tb_ysyx_23060201_ifu_hs.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_pkg.sv
// rtl/ysyx_23060201_pkg.sv - IFU shared types and constants
package ysyx_23060201_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } ifu_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060201_ifu_fifo.sv
// rtl/ysyx_23060201_ifu_fifo.sv - registered-output instruction buffer with synchronous flush
module ysyx_23060201_ifu_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: head is only meaningful while valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign valid = (count != '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/ysyx_23060201_ifu_hs.sv
// rtl/ysyx_23060201_ifu_hs.sv - handshaked instruction fetch unit; IFU_RRESP_CHK_EN enables fault halt
module ysyx_23060201_ifu_hs
   import ysyx_23060201_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC),
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic                  out_fault
);

   localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   ifu_state_e            state, state_next;
   logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;
   logic [ADDR_WIDTH-1:0] ar_pc;
   logic                  drop;
   logic                  halt, halt_next;
   logic                  ar_hs, r_hs, push, pop, rsp_fault, slot_free;
   logic [CW-1:0]         count, count_next;
   logic [EW-1:0]         head;
   logic                  head_fault;

`ifdef IFU_RRESP_CHK_EN
   assign rsp_fault = (rresp != RESP_OKAY);
`else
   logic unused_rresp;
   assign unused_rresp = ^rresp;
   assign rsp_fault    = 1'b0;
`endif

   assign arvalid = (state == REQ);
   assign rready  = (state == WAIT);
   assign araddr  = ar_pc;
   assign ar_hs   = arvalid && arready;
   assign r_hs    = rvalid && rready;
   // A redirect flushes, so neither a stale response nor the head dequeue survives it.
   assign push    = r_hs && !drop && !redirect_valid;
   assign pop     = out_valid && out_ready && !redirect_valid;

   assign count_next = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
   assign slot_free  = (count_next < CW'(FIFO_DEPTH));
   assign halt_next  = redirect_valid ? 1'b0 : (halt || (push && rsp_fault));

   always_comb begin
      fetch_pc_next = fetch_pc;
      if (redirect_valid)
         fetch_pc_next = redirect_pc & ~ADDR_WIDTH'(3);
      else if (push)
         fetch_pc_next = fetch_pc + ADDR_WIDTH'(4);
   end

   always_comb begin
      state_next = state;
      unique case (state)
         REQ:  if (ar_hs) state_next = WAIT;
         WAIT: if (r_hs)  state_next = (slot_free && !halt_next) ? REQ : HOLD;
         HOLD: if (slot_free && !halt_next) state_next = REQ;
         default: state_next = HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= HOLD;
         fetch_pc <= RESET_PC;
         ar_pc    <= RESET_PC;
         drop     <= 1'b0;
         halt     <= 1'b0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         halt     <= halt_next;
         // The address is latched on entry to REQ so a redirect cannot move a pending AR.
         if (state_next == REQ && state != REQ)
            ar_pc <= fetch_pc_next;
         if (redirect_valid)
            drop <= (state == REQ) || (state == WAIT && !r_hs);
         else if (r_hs)
            drop <= 1'b0;
      end
   end

   ysyx_23060201_ifu_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({ar_pc, rdata, rsp_fault}),
      .pop       (pop),
      .valid     (out_valid),
      .head      (head),
      .count     (count)
   );

   assign {out_pc, out_inst, head_fault} = head;
   assign out_fault = out_valid && head_fault;

endmodule

// File: tb/tb_ysyx_23060201_ifu_hs.sv
// tb/tb_ysyx_23060201_ifu_hs.sv - scoreboard bench for the handshaked IFU
module tb_ysyx_23060201_ifu_hs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic        rvalid, rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        out_valid, out_fault;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_inst;

   always #5 clk = ~clk;

   ysyx_23060201_ifu_hs dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .arvalid        (arvalid),
      .arready        (arready),
      .araddr         (araddr),
      .rvalid         (rvalid),
      .rready         (rready),
      .rdata          (rdata),
      .rresp          (rresp),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_fault      (out_fault)
   );

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] ar_q[$];
   logic [64:0] out_q[$];

   int          mem_budget = 0;
   int          mem_ar_delay = 0;
   int          mem_rlat = 1;
   logic [1:0]  mem_resp = 2'b00;
   int          ar_cnt = 0;
   int          pend_cnt = 0;
   bit          pend = 0;
   bit          ar_fire, r_fire;
   logic [31:0] pend_addr, fire_addr;

   task automatic check(input string name, input logic [64:0] got, input logic [64:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [64:0] ent(input logic [31:0] pc, input logic [31:0] inst, input logic f);
      return {pc, inst, f};
   endfunction

   // Memory: returns addr ^ 0x413; arready after mem_ar_delay cycles, rvalid mem_rlat cycles after AR.
   initial begin
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = '0;
      rresp   = 2'b00;
      forever begin
         @(negedge clk);
         ar_fire   = arvalid && arready;
         r_fire    = rvalid && rready;
         fire_addr = araddr;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pend    = 0;
            rvalid  = 1'b0;
            arready = 1'b0;
            ar_cnt  = mem_ar_delay;
         end else begin
            if (r_fire) begin
               rvalid = 1'b0;
               pend   = 0;
            end
            if (ar_fire) begin
               pend      = 1;
               pend_addr = fire_addr;
               pend_cnt  = mem_rlat;
               ar_cnt    = mem_ar_delay;
               if (mem_budget > 0) mem_budget--;
            end
            if (pend && !rvalid) begin
               if (pend_cnt > 1) pend_cnt--;
               else begin
                  rvalid = 1'b1;
                  rdata  = pend_addr ^ 32'h0000_0413;
                  rresp  = mem_resp;
               end
            end
            arready = 1'b0;
            if (arvalid && !pend && mem_budget > 0) begin
               if (ar_cnt > 0) ar_cnt--;
               else arready = 1'b1;
            end
         end
      end
   end

   // Monitor: pops expected AR addresses and output entries on each handshake.
   initial begin
      bit          prev_pend;
      logic [31:0] prev_addr;
      prev_pend = 0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_pend = 0;
         end else begin
            if (prev_pend)
               check("ar_stable", 65'({arvalid, araddr}), 65'({1'b1, prev_addr}));
            prev_pend = arvalid && !arready;
            prev_addr = araddr;
            if (arvalid && arready) begin
               if (ar_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL ar_unexpected: got araddr %h want none", araddr);
               end else
                  check("ar_addr", 65'(araddr), 65'(ar_q.pop_front()));
            end
            if (out_valid && out_ready) begin
               if (out_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL out_unexpected: got pc %h inst %h want none", out_pc, out_inst);
               end else
                  check("out_entry", {out_pc, out_inst, out_fault}, out_q.pop_front());
            end
         end
      end
   end

   task automatic do_reset(input int budget, input int ar_delay, input int rlat, input logic ready);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = ready;
      mem_budget     = budget;
      mem_ar_delay   = ar_delay;
      mem_rlat       = rlat;
      repeat (3) tick();
      check("reset_outs", 65'({arvalid, rready, out_valid, out_fault}), 65'(0));
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name, input int max);
      int n = 0;
      while ((ar_q.size() != 0 || out_q.size() != 0) && n < max) begin
         tick();
         n++;
      end
      check(name, 65'(ar_q.size() + out_q.size()), 65'(0));
      repeat (3) tick();
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      // Basic zero-wait fetch and first-output latency.
      ar_q.push_back(32'h8000_0000); ar_q.push_back(32'h8000_0004); ar_q.push_back(32'h8000_0008);
      out_q.push_back(ent(32'h8000_0000, 32'h8000_0413, 1'b0));
      out_q.push_back(ent(32'h8000_0004, 32'h8000_0417, 1'b0));
      out_q.push_back(ent(32'h8000_0008, 32'h8000_041B, 1'b0));
      do_reset(3, 0, 1, 1'b1);
      tick();
      check("first_ar", 65'({arvalid, araddr, out_valid}), 65'({1'b1, 32'h8000_0000, 1'b0}));
      tick();
      check("cyc2_out_valid", 65'(out_valid), 65'(0));
      tick();
      check("cyc3_out", 65'({out_valid, out_pc}), 65'({1'b1, 32'h8000_0000}));
      drain("drain_basic", 50);

      // Back-pressure: FIFO of two fills, then AR stops until drained.
      ar_q.push_back(32'h8000_0000); ar_q.push_back(32'h8000_0004);
      do_reset(4, 0, 1, 1'b0);
      repeat (10) tick();
      check("full_hold", 65'({arvalid, out_valid, out_pc}), 65'({1'b0, 1'b1, 32'h8000_0000}));
      check("full_arq_empty", 65'(ar_q.size()), 65'(0));
      ar_q.push_back(32'h8000_0008); ar_q.push_back(32'h8000_000C);
      out_q.push_back(ent(32'h8000_0000, 32'h8000_0413, 1'b0));
      out_q.push_back(ent(32'h8000_0004, 32'h8000_0417, 1'b0));
      out_q.push_back(ent(32'h8000_0008, 32'h8000_041B, 1'b0));
      out_q.push_back(ent(32'h8000_000C, 32'h8000_041F, 1'b0));
      out_ready = 1'b1;
      drain("drain_backpressure", 60);

      // arready delayed 3 cycles: address held, single enqueue.
      ar_q.push_back(32'h8000_0000);
      out_q.push_back(ent(32'h8000_0000, 32'h8000_0413, 1'b0));
      do_reset(1, 3, 1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ar_delay_hold", 65'({arvalid, arready, araddr}), 65'({1'b1, 1'b0, 32'h8000_0000}));
      end
      drain("drain_ar_delay", 50);

      // Redirect during WAIT: in-flight response dropped, fetch resumes at aligned target.
      ar_q.push_back(32'h8000_0000); ar_q.push_back(32'h8000_0100); ar_q.push_back(32'h8000_0104);
      out_q.push_back(ent(32'h8000_0100, 32'h8000_0513, 1'b0));
      out_q.push_back(ent(32'h8000_0104, 32'h8000_0517, 1'b0));
      do_reset(3, 0, 3, 1'b1);
      begin
         int n = 0;
         while (!rready && n < 20) begin tick(); n++; end
         check("reach_wait", 65'(rready), 65'(1));
      end
      redirect(32'h8000_0103);
      check("redir_flush", 65'(out_valid), 65'(0));
      drain("drain_redirect", 60);

      // Redirect while AR pending (not withdrawn), then PC wraps past 0xFFFFFFFC.
      do_reset(0, 0, 1, 1'b1);
      tick(); tick();
      check("ar_pending", 65'({arvalid, araddr}), 65'({1'b1, 32'h8000_0000}));
      redirect(32'hFFFF_FFFC);
      check("ar_not_withdrawn", 65'({arvalid, araddr, out_valid}), 65'({1'b1, 32'h8000_0000, 1'b0}));
      ar_q.push_back(32'h8000_0000); ar_q.push_back(32'hFFFF_FFFC); ar_q.push_back(32'h0000_0000);
      out_q.push_back(ent(32'hFFFF_FFFC, 32'hFFFF_FBEF, 1'b0));
      out_q.push_back(ent(32'h0000_0000, 32'h0000_0413, 1'b0));
      mem_budget = 3;
      drain("drain_wrap", 60);

      // Error response handling.
      mem_resp = 2'b10;
`ifdef IFU_RRESP_CHK_EN
      ar_q.push_back(32'h8000_0000);
      out_q.push_back(ent(32'h8000_0000, 32'h8000_0413, 1'b1));
      do_reset(3, 0, 1, 1'b1);
      drain("drain_fault", 50);
      repeat (5) tick();
      check("fault_halt", 65'(arvalid), 65'(0));
      mem_resp = 2'b00;
      ar_q.push_back(32'h8000_0200);
      out_q.push_back(ent(32'h8000_0200, 32'h8000_0613, 1'b0));
      mem_budget = 1;
      redirect(32'h8000_0200);
      drain("drain_fault_resume", 50);
`else
      ar_q.push_back(32'h8000_0000); ar_q.push_back(32'h8000_0004);
      out_q.push_back(ent(32'h8000_0000, 32'h8000_0413, 1'b0));
      out_q.push_back(ent(32'h8000_0004, 32'h8000_0417, 1'b0));
      do_reset(2, 0, 1, 1'b1);
      drain("drain_resp_ignored", 50);
      mem_resp = 2'b00;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
